uart_tx: RTL
============

Name: uart_tx

Overview:
- UART transmitter, companion to the existing oversampled receiver. It serialises bytes onto a single line.
- Bit period is CLKS_PER_BIT cycles of s_clk_i. The default of 16 matches the receiver's oversample ratio, so both blocks share one clock.
- Frame format: one start bit (0), 8 data bits MSB first, then STOP_BITS stop bits (1). The receiver shifts each sampled bit into the LSB, so the first bit sent lands in bit 7.
- A one-entry holding register allows back-to-back frames with no idle gap between them.

Parameters:
- CLKS_PER_BIT, 16: s_clk_i cycles per bit; legal range 2..256.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- s_clk_i  in  1  system/oversample clock; all logic on posedge.
- rst_i  in  1  asynchronous, active-high reset.
- data_i  in  8  byte to transmit.
- data_valid_i  in  1  data_i valid.
- data_ready_o  out  1  block can accept a byte; transfer occurs on a posedge where valid & ready = 1.
- tx_o  out  1  serial line; registered; idles high.
- busy_o  out  1  high while any frame bit is on the line, or while the holding register is full.

Behaviour:
- Reset values: tx_o=1, data_ready_o=1, busy_o=0. FSM=IDLE, holding register empty, counters=0. Reset asserted mid-frame aborts the frame and forces tx_o=1 asynchronously; no partial frame resumes after reset.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- Bit timer counts 0..CLKS_PER_BIT-1. Every state other than IDLE lasts exactly CLKS_PER_BIT cycles per bit.
- Bit counter: 0..7 in DATA, 0..STOP_BITS-1 in STOP.
- IDLE:
  - On a handshake edge with the holding register empty, data_i loads directly into the shifter (bypass). FSM goes to START and tx_o=0 from that same edge, so latency is 0 cycles after acceptance.
  - If the holding register is full, its byte loads into the shifter on the next edge.
- START: tx_o=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx_o = shifter[7]. Shift left at the end of each bit period. After 8 bits go to STOP (or PARITY).
- STOP: tx_o=1 for STOP_BITS*CLKS_PER_BIT cycles. At the last cycle of the final stop bit:
  - If the holding register is full, or a handshake occurs on that same edge, load the shifter and go directly to START. There is no idle gap.
  - Otherwise go to IDLE.
- Holding register and data_ready_o:
  - data_ready_o is high exactly when the holding register is empty.
  - A handshake while a frame is in progress fills the holding register.
  - Loading the shifter from the holding register empties it.
  - If a fill and a drain happen on the same edge, the register stays full with the new byte.
- data_valid_i while data_ready_o=0 is ignored: no capture, and data_i may change freely.
- Total frame length without parity: (10 + STOP_BITS - 1) * CLKS_PER_BIT cycles; 160 cycles at the defaults.
- busy_o is registered and falls on the edge at which the FSM enters IDLE with the holding register empty.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - A parameter PARITY_ODD (default 0) is added. The bit sent is the XOR of the 8 data bits, inverted when PARITY_ODD=1.
  - Frame length grows by one bit.
- Undefined: no PARITY state and no PARITY_ODD parameter. Frame is start + 8 data + stop.

Test Plan:
- Reset behaviour: hold rst_i for 3 cycles, then release -> tx_o=1, data_ready_o=1, busy_o=0. Assert rst_i at cycle 50 of a frame -> tx_o=1 immediately; no further frame bits appear.
- Single byte 0xA5, 10 ns clock -> tx_o is low for 160 ns, then 1,0,1,0,0,1,0,1 at 160 ns per bit, then high for 160 ns. busy_o falls 1600 ns after acceptance.
- Back-to-back 0x3C then 0xC3: the second byte is presented while the first is in DATA.
  - data_ready_o drops after the second handshake.
  - The second start bit begins on the cycle immediately after the first stop bit ends; the line is never high longer than one bit.
  - A third byte is not accepted until the second byte's START.
- Stall: hold data_valid_i=1 while data_ready_o=0 and change data_i each cycle -> only the value present on the accepting edge is transmitted.
- Loopback: drive tx_o into the UART receiver with a shared s_clk_i, sending 0x55, 0x00, 0xFF, 0x81 -> the receiver reports each value with data_ready_o pulsing once per frame. Repeat with STOP_BITS=2.
- With UART_TX_PARITY_EN and PARITY_ODD=0: send 0x07 -> parity bit=1. With PARITY_ODD=1: send 0x07 -> parity bit=0. Frame length is 176 cycles in both cases.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits MSB first, STOP_BITS stop bits, with a
// one-entry holding register for gap-free frames. Define UART_TX_PARITY_EN to add a parity bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       s_clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST_CLK  = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shifter;
  logic [7:0]    hold;
  logic          hold_full;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  logic       handshake, bit_end, stop_last, load, fill;
  logic [7:0] load_byte;

  assign data_ready_o = ~hold_full;
  assign handshake    = data_valid_i & data_ready_o;
  assign bit_end      = (timer == LAST_CLK);
  assign stop_last    = (state == STOP) && bit_end && (bit_cnt == LAST_STOP);
  // A queued byte always wins over the input; both can't be offered at once since ready is low.
  assign load         = ((state == IDLE) || stop_last) && (hold_full || handshake);
  assign load_byte    = hold_full ? hold : data_i;
  assign fill         = handshake && (state != IDLE) && !stop_last;

  always_ff @(posedge s_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      shifter   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      tx_o      <= 1'b1;
      busy_o    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      if (state == IDLE || bit_end || load) timer <= '0;
      else                                   timer <= timer + 1'b1;

      if (load) begin
        shifter <= load_byte;
        state   <= START;
        tx_o    <= 1'b0;
        busy_o  <= 1'b1;
        bit_cnt <= '0;
        if (hold_full) hold_full <= 1'b0;
`ifdef UART_TX_PARITY_EN
        par     <= (^load_byte) ^ PARITY_ODD;
`endif
      end else begin
        case (state)
          IDLE: ;
          START: if (bit_end) begin
            state   <= DATA;
            tx_o    <= shifter[7];
            bit_cnt <= '0;
          end
          DATA: if (bit_end) begin
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx_o    <= par;
`else
              state   <= STOP;
              tx_o    <= 1'b1;
`endif
            end else begin
              shifter <= {shifter[6:0], 1'b0};
              tx_o    <= shifter[6];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: if (bit_end) begin
            state   <= STOP;
            tx_o    <= 1'b1;
            bit_cnt <= '0;
          end
`endif
          STOP: if (bit_end) begin
            // Reaching the last stop bit here means nothing was queued, so the line goes idle.
            if (bit_cnt == LAST_STOP) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end

      if (fill) begin
        hold      <= data_i;
        hold_full <= 1'b1;
      end
    end
  end

endmodule
